// File: rtl/mmio_pkg.sv
// Shared register offsets, STATUS bit positions and transmitter FSM encoding
// for the memory-mapped UART transmitter.
package mmio_pkg;

  localparam logic [2:0] TXDATA_OFS = 3'd0;
  localparam logic [2:0] STATUS_OFS = 3'd4;

  localparam int unsigned ST_BUSY  = 0;
  localparam int unsigned ST_FULL  = 1;
  localparam int unsigned ST_EMPTY = 2;
  localparam int unsigned ST_OVF   = 3;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-around pointers and an occupancy counter.
// The head entry is presented combinationally on dout.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Push is judged on the pre-edge full flag, so a simultaneous pop never frees room.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 serial transmitter: TXDATA/STATUS register window,
// TX FIFO, sticky overflow flag, and the start/data/stop shifting FSM.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy,
  output logic        tx_done
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t     state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    shreg, shreg_n;
  logic          tx_n;
  logic          done_n;
  logic          overflow;

  logic          wr_en;
  logic          is_status;
  logic          push_req;
  logic          status_wr;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic          unused_bits;

  assign unused_bits = ^{dataadr[1:0], writedata[31:8]};

  assign sel       = (dataadr[31:3] == BASE_ADDR[31:3]);
  assign wr_en     = memwrite && sel;
  assign is_status = (dataadr[2] == STATUS_OFS[2]);
  assign push_req  = wr_en && !is_status;
  assign status_wr = wr_en && is_status;
  assign busy      = (state != IDLE) || !fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (fifo_pop),
    .din   (writedata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A dropped push outranks a same-edge STATUS write.
  always_ff @(posedge clk) begin
    if (reset)                       overflow <= 1'b0;
    else if (push_req && fifo_full)  overflow <= 1'b1;
    else if (status_wr)              overflow <= 1'b0;
  end

  always_comb begin
    rdata = '0;
    if (sel && is_status) begin
      rdata[ST_BUSY]  = busy;
      rdata[ST_FULL]  = fifo_full;
      rdata[ST_EMPTY] = fifo_empty;
      rdata[ST_OVF]   = overflow;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_cnt <= bit_n;
      shreg   <= shreg_n;
      tx      <= tx_n;
      tx_done <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    baud_n   = (baud == BAUD_LAST) ? '0 : baud + 1'b1;
    bit_n    = bit_cnt;
    shreg_n  = shreg;
    fifo_pop = 1'b0;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        baud_n = '0;
        if (!fifo_empty) begin
          state_n  = START;
          fifo_pop = 1'b1;
          shreg_n  = fifo_dout;
        end
      end
      START: begin
        if (baud == BAUD_LAST) begin
          state_n = DATA;
          bit_n   = '0;
        end
      end
      DATA: begin
        if (baud == BAUD_LAST) begin
          if (bit_cnt == 3'd7) state_n = STOP;
          else                 bit_n   = bit_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud == BAUD_LAST) begin
          done_n = 1'b1;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            state_n  = START;
            fifo_pop = 1'b1;
            shreg_n  = fifo_dout;
          end else begin
            state_n  = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n != state) baud_n = '0;

    // tx is registered from the next state so the line changes on the transition edge.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[bit_n];
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register-decode table plus frame,
// back-to-back, overflow, foreign-address and mid-frame reset sequences.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  localparam logic [31:0] STAT = 32'hFFFF_FF04;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic        sel;
  logic [31:0] rdata;
  logic        tx;
  logic        busy;
  logic        tx_done;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [7:0] fb [8];
  int         nb;

  typedef struct {
    logic [31:0] adr;
    logic        exp_sel;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt [8];

  mmio_uart_tx #(
    .BASE_ADDR    (32'hFFFF_FF00),
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .sel       (sel),
    .rdata     (rdata),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; holds the store across one rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite  = 1'b1;
    dataadr   = a;
    writedata = d;
    @(negedge clk);
    memwrite  = 1'b0;
  endtask

  task automatic rd_status(input string name, input logic [31:0] exp);
    dataadr = STAT;
    #1;
    chk(name, rdata, exp);
  endtask

  // k counts negedges after the edge on which the first frame's start bit begins.
  task automatic check_frames(input int kstart);
    int p;
    int f;
    logic [7:0] b;
    logic exp_tx;
    logic exp_done;
    for (int k = kstart; k <= 40 * nb + 1; k++) begin
      if (k <= 40 * nb) begin
        f = (k - 1) / 40;
        p = ((k - 1) % 40) / 4;
        b = fb[f];
        if (p == 0)      exp_tx = 1'b0;
        else if (p == 9) exp_tx = 1'b1;
        else             exp_tx = b[p-1];
      end else begin
        exp_tx = 1'b1;
      end
      exp_done = (k > 1) && ((k - 1) % 40 == 0);
      chk($sformatf("tx k=%0d", k), {31'b0, tx}, {31'b0, exp_tx});
      chk($sformatf("tx_done k=%0d", k), {31'b0, tx_done}, {31'b0, exp_done});
      @(negedge clk);
    end
  endtask

  initial begin
    logic bad;

    vt[0] = '{32'hFFFF_FF04, 1'b1, 32'h0000_0004};
    vt[1] = '{32'hFFFF_FF00, 1'b1, 32'h0000_0000};
    vt[2] = '{32'hFFFF_FF07, 1'b1, 32'h0000_0004};
    vt[3] = '{32'hFFFF_FF03, 1'b1, 32'h0000_0000};
    vt[4] = '{32'hFFFF_FF08, 1'b0, 32'h0000_0000};
    vt[5] = '{32'hFFFF_FEFC, 1'b0, 32'h0000_0000};
    vt[6] = '{32'h0000_0054, 1'b0, 32'h0000_0000};
    vt[7] = '{32'h7FFF_FF04, 1'b0, 32'h0000_0000};

    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      dataadr = vt[i].adr;
      #1;
      chk($sformatf("sel[%0d]", i), {31'b0, sel}, {31'b0, vt[i].exp_sel});
      if (vt[i].exp_sel) chk($sformatf("rdata[%0d]", i), rdata, vt[i].exp_rdata);
    end
    chk("reset tx", {31'b0, tx}, 32'd1);
    chk("reset tx_done", {31'b0, tx_done}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);

    // Single frame 0x55
    @(negedge clk);
    wr(BASE, 32'h55);
    rd_status("status after push", 32'h1);
    chk("tx before start", {31'b0, tx}, 32'd1);
    @(negedge clk);
    fb[0] = 8'h55;
    nb = 1;
    check_frames(1);
    chk("busy after 55", {31'b0, busy}, 32'd0);
    rd_status("status after 55", 32'h4);

    // Back-to-back frames
    wr(BASE, 32'hA5);
    wr(BASE, 32'h3C);
    fb[0] = 8'hA5;
    fb[1] = 8'h3C;
    nb = 2;
    check_frames(1);
    chk("busy after pair", {31'b0, busy}, 32'd0);

    // Overflow: six stores, the sixth is dropped
    for (int i = 0; i < 6; i++) wr(BASE, 32'h11 + i);
    rd_status("status overflow", 32'hB);
    memwrite  = 1'b1;
    writedata = 32'h0;
    @(negedge clk);
    memwrite  = 1'b0;
    rd_status("status ovf cleared", 32'h3);
    for (int i = 0; i < 5; i++) fb[i] = 8'h11 + 8'(i);
    nb = 5;
    check_frames(6);
    rd_status("status after drain", 32'h4);

    // Store to an address outside the window
    memwrite  = 1'b1;
    dataadr   = 32'h0000_0054;
    writedata = 32'h7;
    #1;
    chk("foreign sel", {31'b0, sel}, 32'd0);
    @(negedge clk);
    memwrite = 1'b0;
    bad = 1'b0;
    repeat (12) begin
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    chk("foreign idle", {31'b0, bad}, 32'd0);
    rd_status("foreign status", 32'h4);

    // Reset 15 cycles into a frame
    wr(BASE, 32'h5A);
    repeat (15) @(negedge clk);
    chk("pre-reset busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort tx", {31'b0, tx}, 32'd1);
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort tx_done", {31'b0, tx_done}, 32'd0);
    rd_status("abort status", 32'h4);
    bad = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    chk("no tx after abort", {31'b0, bad}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
